// File: rtl/rv32i_decode_exec.sv
// RV32I decode + execute slice: combinational source-index extraction, a decode
// register, then a result register (two-cycle instruction-to-result latency).
module rv32i_decode_exec #(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [31:0]     INSTRUCTION,
    input  logic [XLEN-1:0] PC,
    output logic [4:0]      RS1,
    output logic [4:0]      RS2,
    input  logic [XLEN-1:0] RS1_VAL,
    input  logic [XLEN-1:0] RS2_VAL,
    output logic [4:0]      RD,
    output logic            WE,
    output logic [XLEN-1:0] EXEC_RESULT,
    output logic            ILLEGAL
);

    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcOpImm = 7'b0010011;
    localparam logic [6:0] OpcLui   = 7'b0110111;
    localparam logic [6:0] OpcAuipc = 7'b0010111;
    localparam logic [6:0] OpcJal   = 7'b1101111;
    localparam logic [6:0] OpcJalr  = 7'b1100111;

    // AluNone is the reset encoding and yields a zero result.
    typedef enum logic [3:0] {
        AluNone, AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor,
        AluSrl, AluSra, AluOr, AluAnd, AluLui, AluAuipc, AluLink
    } alu_op_e;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;

    assign opcode = INSTRUCTION[6:0];
    assign rd     = INSTRUCTION[11:7];
    assign funct3 = INSTRUCTION[14:12];
    assign funct7 = INSTRUCTION[31:25];
    assign imm_i  = {{(XLEN-12){INSTRUCTION[31]}}, INSTRUCTION[31:20]};
    assign imm_u  = {INSTRUCTION[31:12], 12'b0};

    assign RS1 = INSTRUCTION[19:15];
    assign RS2 = INSTRUCTION[24:20];

    alu_op_e         op_d, op_q;
    logic [XLEN-1:0] imm_d, imm_q;
    logic            use_imm_d, use_imm_q;
    logic [XLEN-1:0] pc_q;
    logic [4:0]      rd_q;
    logic            we_q, illegal_q;
    logic            legal;

    always_comb begin
        op_d      = AluNone;
        imm_d     = '0;
        use_imm_d = 1'b0;
        legal     = 1'b0;
        case (opcode)
            OpcOp: begin
                if (funct7 == 7'b0000000) begin
                    legal = 1'b1;
                    case (funct3)
                        3'b000:  op_d = AluAdd;
                        3'b001:  op_d = AluSll;
                        3'b010:  op_d = AluSlt;
                        3'b011:  op_d = AluSltu;
                        3'b100:  op_d = AluXor;
                        3'b101:  op_d = AluSrl;
                        3'b110:  op_d = AluOr;
                        default: op_d = AluAnd;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    legal = 1'b1;
                    op_d  = AluSub;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    legal = 1'b1;
                    op_d  = AluSra;
                end
            end
            OpcOpImm: begin
                use_imm_d = 1'b1;
                imm_d     = imm_i;
                legal     = 1'b1;
                case (funct3)
                    3'b000: op_d = AluAdd;
                    3'b010: op_d = AluSlt;
                    3'b011: op_d = AluSltu;
                    3'b100: op_d = AluXor;
                    3'b110: op_d = AluOr;
                    3'b111: op_d = AluAnd;
                    3'b001: begin
                        op_d  = AluSll;
                        legal = (funct7 == 7'b0000000);
                    end
                    default: begin
                        if (funct7 == 7'b0000000) begin
                            op_d = AluSrl;
                        end else if (funct7 == 7'b0100000) begin
                            op_d = AluSra;
                        end else begin
                            legal = 1'b0;
                        end
                    end
                endcase
            end
            OpcLui: begin
                legal = 1'b1;
                op_d  = AluLui;
                imm_d = imm_u;
            end
            OpcAuipc: begin
                legal = 1'b1;
                op_d  = AluAuipc;
                imm_d = imm_u;
            end
            OpcJal: begin
                legal = 1'b1;
                op_d  = AluLink;
            end
            OpcJalr: begin
                legal = (funct3 == 3'b000);
                op_d  = AluLink;
            end
            default: legal = 1'b0;
        endcase
        // Illegal encodings must not leak a partial result into stage 2.
        if (!legal) begin
            op_d      = AluNone;
            imm_d     = '0;
            use_imm_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            op_d_reset();
        end else begin
            op_q      <= op_d;
            imm_q     <= imm_d;
            use_imm_q <= use_imm_d;
            pc_q      <= PC;
            rd_q      <= rd;
            we_q      <= legal && (rd != 5'd0);
            illegal_q <= !legal;
        end
    end

    task automatic op_d_reset();
        op_q      <= AluNone;
        imm_q     <= '0;
        use_imm_q <= 1'b0;
        pc_q      <= '0;
        rd_q      <= '0;
        we_q      <= 1'b0;
        illegal_q <= 1'b0;
    endtask

    logic [XLEN-1:0] operand_b;
    logic [4:0]      shamt;
    logic [XLEN-1:0] result_d;

    assign operand_b = use_imm_q ? imm_q : RS2_VAL;
    assign shamt     = operand_b[4:0];

    always_comb begin
        result_d = '0;
        case (op_q)
            AluAdd:   result_d = RS1_VAL + operand_b;
            AluSub:   result_d = RS1_VAL - operand_b;
            AluSll:   result_d = RS1_VAL << shamt;
            AluSlt:   result_d = {{(XLEN-1){1'b0}}, $signed(RS1_VAL) < $signed(operand_b)};
            AluSltu:  result_d = {{(XLEN-1){1'b0}}, RS1_VAL < operand_b};
            AluXor:   result_d = RS1_VAL ^ operand_b;
            AluSrl:   result_d = RS1_VAL >> shamt;
            AluSra:   result_d = $unsigned($signed(RS1_VAL) >>> shamt);
            AluOr:    result_d = RS1_VAL | operand_b;
            AluAnd:   result_d = RS1_VAL & operand_b;
            AluLui:   result_d = imm_q;
            AluAuipc: result_d = pc_q + imm_q;
            AluLink:  result_d = pc_q + XLEN'(4);
            default:  result_d = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            RD          <= '0;
            WE          <= 1'b0;
            ILLEGAL     <= 1'b0;
            EXEC_RESULT <= '0;
        end else begin
            RD          <= rd_q;
            WE          <= we_q;
            ILLEGAL     <= illegal_q;
            EXEC_RESULT <= result_d;
        end
    end

endmodule

// File: tb/tb_rv32i_decode_exec.sv
// Streams directed and random instructions through rv32i_decode_exec, one per cycle,
// and compares every result against a behavioural RV32I model.
module tb_rv32i_decode_exec;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] INSTRUCTION, PC, RS1_VAL, RS2_VAL;
    logic [4:0]  RS1, RS2, RD;
    logic        WE, ILLEGAL;
    logic [31:0] EXEC_RESULT;

    int checks   = 0;
    int failures = 0;

    rv32i_decode_exec #(.XLEN(32)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .INSTRUCTION (INSTRUCTION),
        .PC          (PC),
        .RS1         (RS1),
        .RS2         (RS2),
        .RS1_VAL     (RS1_VAL),
        .RS2_VAL     (RS2_VAL),
        .RD          (RD),
        .WE          (WE),
        .EXEC_RESULT (EXEC_RESULT),
        .ILLEGAL     (ILLEGAL)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
        logic [31:0] res;
    } entry_t;

    entry_t q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Architectural reference: what an RV32I core would write back for this instruction.
    function automatic void model(input logic [31:0] inst, input logic [31:0] pc,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic we, output logic ill, output logic [31:0] res);
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [31:0] immu;
        f7   = inst[31:25];
        f3   = inst[14:12];
        imm  = {{20{inst[31]}}, inst[31:20]};
        immu = {inst[31:12], 12'h000};
        ill  = 1'b0;
        res  = 32'h0;
        case (inst[6:0])
            7'b0110011: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: res = a + b;
                        3'd1: res = a << b[4:0];
                        3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        3'd3: res = (a < b) ? 32'd1 : 32'd0;
                        3'd4: res = a ^ b;
                        3'd5: res = a >> b[4:0];
                        3'd6: res = a | b;
                        3'd7: res = a & b;
                        default: res = 32'h0;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'd0) res = a - b;
                else if (f7 == 7'h20 && f3 == 3'd5) res = $unsigned($signed(a) >>> b[4:0]);
                else ill = 1'b1;
            end
            7'b0010011: begin
                case (f3)
                    3'd0: res = a + imm;
                    3'd2: res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
                    3'd3: res = (a < imm) ? 32'd1 : 32'd0;
                    3'd4: res = a ^ imm;
                    3'd6: res = a | imm;
                    3'd7: res = a & imm;
                    3'd1: if (f7 == 7'h00) res = a << inst[24:20]; else ill = 1'b1;
                    default: begin
                        if (f7 == 7'h00) res = a >> inst[24:20];
                        else if (f7 == 7'h20) res = $unsigned($signed(a) >>> inst[24:20]);
                        else ill = 1'b1;
                    end
                endcase
            end
            7'b0110111: res = immu;
            7'b0010111: res = pc + immu;
            7'b1101111: res = pc + 32'd4;
            7'b1100111: if (f3 == 3'd0) res = pc + 32'd4; else ill = 1'b1;
            default:    ill = 1'b1;
        endcase
        if (ill) res = 32'h0;
        we = !ill && (inst[11:7] != 5'd0);
    endfunction

    task automatic add_dir(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] a,
                           input logic [31:0] b, input logic we, input logic ill,
                           input logic [31:0] res);
        entry_t e;
        e.inst = inst; e.pc = pc; e.a = a; e.b = b;
        e.rd = inst[11:7]; e.we = we; e.ill = ill; e.res = res;
        q.push_back(e);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic add_rand();
        logic [6:0]  ops [11];
        logic [6:0]  f7;
        logic [31:0] r;
        entry_t      e;
        ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                7'b0000011, 7'b0100011, 7'b1100011, 7'b0001111, 7'b1110011};
        r = $urandom;
        case ($urandom_range(0, 3))
            0, 1:    f7 = 7'h00;
            2:       f7 = 7'h20;
            default: f7 = r[31:25];
        endcase
        if ($urandom_range(0, 7) == 0) e.inst = $urandom;
        else e.inst = {f7, r[24:7], ops[$urandom_range(0, 10)]};
        e.pc = $urandom & 32'hFFFF_FFFC;
        e.a  = pick_operand();
        e.b  = pick_operand();
        e.rd = e.inst[11:7];
        model(e.inst, e.pc, e.a, e.b, e.we, e.ill, e.res);
        q.push_back(e);
    endtask

    task automatic check_out(input string tag, input entry_t e);
        check({tag, ".rd"},  {27'h0, RD},          {27'h0, e.rd});
        check({tag, ".we"},  {31'h0, WE},          {31'h0, e.we});
        check({tag, ".ill"}, {31'h0, ILLEGAL},     {31'h0, e.ill});
        check({tag, ".res"}, EXEC_RESULT,          e.res);
    endtask

    initial begin
        entry_t e;
        int     n;
        RST = 1'b1; INSTRUCTION = 32'h002181B3; PC = 32'h0; RS1_VAL = 32'h0; RS2_VAL = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset.rd",  {27'h0, RD}, 32'h0);
        check("reset.we",  {31'h0, WE}, 32'h0);
        check("reset.ill", {31'h0, ILLEGAL}, 32'h0);
        check("reset.res", EXEC_RESULT, 32'h0);
        check("reset.rs1", {27'h0, RS1}, 32'd3);
        RST = 1'b0;

        add_dir(32'h002181B3, 32'h0,   32'd1,        32'd2, 1'b1, 1'b0, 32'd3);
        add_dir(32'h002182B3, 32'h0,   32'd3,        32'd2, 1'b1, 1'b0, 32'd5);
        add_dir(32'h402181B3, 32'h0,   32'd1,        32'd2, 1'b1, 1'b0, 32'hFFFF_FFFF);
        add_dir(32'h0021A1B3, 32'h0,   32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 32'd1);
        add_dir(32'h0021B1B3, 32'h0,   32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 32'd0);
        add_dir(32'h40415093, 32'h0,   32'h8000_0000, 32'h0, 1'b1, 1'b0, 32'hF800_0000);
        add_dir(32'h00415093, 32'h0,   32'h8000_0000, 32'h0, 1'b1, 1'b0, 32'h0800_0000);
        add_dir(32'h123450B7, 32'h0,   32'h0,        32'h0, 1'b1, 1'b0, 32'h1234_5000);
        add_dir(32'h12345097, 32'h100, 32'h0,        32'h0, 1'b1, 1'b0, 32'h1234_5100);
        add_dir(32'h000000EF, 32'h100, 32'h0,        32'h0, 1'b1, 1'b0, 32'h0000_0104);
        add_dir(32'h00500013, 32'h0,   32'h0,        32'h0, 1'b0, 1'b0, 32'd5);
        add_dir(32'h00002083, 32'h0,   32'h5,        32'h6, 1'b0, 1'b1, 32'h0);
        // SLLI with a non-zero funct7 is not a legal encoding.
        add_dir(32'h02111093, 32'h0,   32'h1,        32'h0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 300; i++) add_rand();

        n = q.size();
        for (int k = 0; k < n + 2; k++) begin
            @(posedge CLK);
            #1;
            if (k >= 2) check_out($sformatf("i%0d", k - 2), q[k - 2]);
            if (k < n) begin
                INSTRUCTION = q[k].inst;
                PC          = q[k].pc;
            end else begin
                INSTRUCTION = 32'h0;
                PC          = 32'h0;
            end
            if (k >= 1 && k <= n) begin
                RS1_VAL = q[k - 1].a;
                RS2_VAL = q[k - 1].b;
            end
            #1;
            if (k < n) begin
                check($sformatf("i%0d.rs1", k), {27'h0, RS1}, {27'h0, q[k].inst[19:15]});
                check($sformatf("i%0d.rs2", k), {27'h0, RS2}, {27'h0, q[k].inst[24:20]});
            end
        end

        // Reset while a LUI is in flight: it must be discarded.
        @(posedge CLK); #1;
        INSTRUCTION = 32'h123450B7; PC = 32'h0;
        @(posedge CLK); #1;
        RST = 1'b1; INSTRUCTION = 32'h002181B3; RS1_VAL = 32'd1; RS2_VAL = 32'd2;
        @(posedge CLK); #1;
        check("rst_mid.rd",  {27'h0, RD}, 32'h0);
        check("rst_mid.we",  {31'h0, WE}, 32'h0);
        check("rst_mid.ill", {31'h0, ILLEGAL}, 32'h0);
        check("rst_mid.res", EXEC_RESULT, 32'h0);
        check("rst_mid.rs1", {27'h0, RS1}, 32'd3);
        RST = 1'b0;
        @(posedge CLK); #1;
        check("rst_gap.we",  {31'h0, WE}, 32'h0);
        @(posedge CLK); #1;
        e.rd = 5'd3; e.we = 1'b1; e.ill = 1'b0; e.res = 32'd3;
        e.inst = 32'h002181B3; e.pc = 32'h0; e.a = 32'd1; e.b = 32'd2;
        check_out("post_rst", e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
